// File: rtl/rl7_line_decoder.sv
// rl7_line_decoder
// Expands CD-i RL7 run-length coded display lines into one byte per pixel.
// The input side is a pixelstream sink (byte stream from the display file
// decoder) and the output side is a one-entry pixelstream source feeding the
// CLUT/pixel pipeline. With rle_enable low at line_start every input byte
// becomes exactly one pixel (CLUT8/DYUV bypass).
//
// Command bytes in RL7 mode:
//   0ccccccc          -> one pixel of colour c
//   1ccccccc nnnnnnnn -> run of colour c, n pixels (n = 0: to end of line)
// Runs are clamped to the pixels left on the line, so position never passes
// line_width; once it gets there the decoder parks in DONE until the next
// line_start, leaving any unread bytes in the upstream FIFO.
module rl7_line_decoder #(
    parameter int unit_index = 0,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic [CNT_W-1:0] line_width,
    input  logic             rle_enable,
    input  logic             in_write,
    input  logic [7:0]       in_pixel,
    output logic             in_strobe,
    output logic             out_write,
    output logic [7:0]       out_pixel,
    input  logic             out_strobe,
    output logic             line_done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_RUN  = 3'd3,
        ST_BYP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Plane index only tags debug output; only planes A (0) and B (1) exist,
    // and nothing in the datapath depends on it.
    if ((unit_index < 0) || (unit_index > 1)) begin : g_unit_index_unexpected
    end

    // Run length for a length byte: 0 means "rest of the line", anything
    // else is clamped to the pixels still missing from the line.
    function automatic logic [CNT_W-1:0] clamp_run(
        input logic [7:0]       len_byte,
        input logic [CNT_W-1:0] remaining
    );
        logic [CNT_W-1:0] len_ext;
        len_ext = CNT_W'(len_byte);
        if (len_byte == 8'd0) begin
            clamp_run = remaining;
        end else if (len_ext > remaining) begin
            clamp_run = remaining;
        end else begin
            clamp_run = len_ext;
        end
    endfunction

    // Registered state
    state_t           state_r;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] position_r;
    logic [CNT_W-1:0] run_r;
    logic [6:0]       colour_r;
    logic             out_write_r;
    logic [7:0]       out_pixel_r;
    logic             line_done_r;

    // Combinational helpers
    logic             slot_free_s;
    logic             room_s;
    logic [CNT_W-1:0] remaining_s;
    logic [CNT_W-1:0] position_inc_s;
    logic             accept_s;
    logic             emit_s;
    logic [7:0]       emit_pixel_s;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] run_nxt_s;
    logic [6:0]       colour_nxt_s;
    logic [CNT_W-1:0] run_len_s;

    // Handshake: a byte is taken only when the output slot can absorb its
    // pixel, the line still has room and no new line is being started.
    always_comb begin
        slot_free_s    = !out_write_r || out_strobe;
        room_s         = (position_r < width_r);
        remaining_s    = width_r - position_r;
        position_inc_s = position_r + CNT_ONE;
        if ((state_r == ST_CMD) || (state_r == ST_LEN) || (state_r == ST_BYP)) begin
            accept_s = in_write && slot_free_s && room_s && !line_start;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign in_strobe = accept_s;

    // Decode: what pixel (if any) is loaded this cycle and where the FSM goes.
    always_comb begin
        emit_s       = 1'b0;
        emit_pixel_s = 8'h00;
        state_nxt_s  = state_r;
        run_nxt_s    = run_r;
        colour_nxt_s = colour_r;
        run_len_s    = clamp_run(in_pixel, remaining_s);
        case (state_r)
            ST_CMD: begin
                if (accept_s && in_pixel[7]) begin
                    colour_nxt_s = in_pixel[6:0];
                    state_nxt_s  = ST_LEN;
                end else if (accept_s) begin
                    emit_s       = 1'b1;
                    emit_pixel_s = {1'b0, in_pixel[6:0]};
                end else begin
                    state_nxt_s  = ST_CMD;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    emit_s       = 1'b1;
                    emit_pixel_s = {1'b0, colour_r};
                    if (run_len_s > CNT_ONE) begin
                        state_nxt_s = ST_RUN;
                        run_nxt_s   = run_len_s - CNT_ONE;
                    end else begin
                        state_nxt_s = ST_CMD;
                        run_nxt_s   = CNT_ZERO;
                    end
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_RUN: begin
                // run_r counts the pixels of the run still to be emitted
                if (run_r == CNT_ZERO) begin
                    state_nxt_s = ST_CMD;
                end else if (slot_free_s && room_s) begin
                    emit_s       = 1'b1;
                    emit_pixel_s = {1'b0, colour_r};
                    run_nxt_s    = run_r - CNT_ONE;
                    if (run_r == CNT_ONE) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BYP: begin
                if (accept_s) begin
                    emit_s       = 1'b1;
                    emit_pixel_s = in_pixel;
                end else begin
                    state_nxt_s  = ST_BYP;
                end
            end
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // The pixel that fills the line ends it, truncating any pending run.
        if (emit_s && (position_inc_s == width_r)) begin
            state_nxt_s = ST_DONE;
            run_nxt_s   = CNT_ZERO;
        end else begin
            run_nxt_s   = run_nxt_s;
        end
    end

    // FSM, position/run counters and the one-entry output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            width_r     <= CNT_ZERO;
            position_r  <= CNT_ZERO;
            run_r       <= CNT_ZERO;
            colour_r    <= 7'h00;
            out_write_r <= 1'b0;
            out_pixel_r <= 8'h00;
            line_done_r <= 1'b1;
        end else if (line_start) begin
            width_r     <= line_width;
            position_r  <= CNT_ZERO;
            run_r       <= CNT_ZERO;
            out_write_r <= 1'b0;
            out_pixel_r <= 8'h00;
            line_done_r <= 1'b0;
            state_r     <= rle_enable ? ST_CMD : ST_BYP;
        end else begin
            state_r  <= state_nxt_s;
            run_r    <= run_nxt_s;
            colour_r <= colour_nxt_s;
            if (emit_s) begin
                out_write_r <= 1'b1;
                out_pixel_r <= emit_pixel_s;
                position_r  <= position_inc_s;
            end else if (out_strobe) begin
                out_write_r <= 1'b0;
            end
            // Line is finished once the last pixel has left the output slot.
            if ((state_r == ST_DONE) && slot_free_s) begin
                line_done_r <= 1'b1;
            end
        end
    end

    assign out_write = out_write_r;
    assign out_pixel = out_pixel_r;
    assign line_done = line_done_r;

endmodule

// File: tb/tb_rl7_line_decoder.sv
// tb_rl7_line_decoder
// Drives byte streams (directed and $urandom) with random upstream gaps and
// downstream backpressure, and compares the pixels, bytes consumed and
// line_done against a line-level reference model of RL7 decoding.
module tb_rl7_line_decoder;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             line_start;
    logic [CNT_W-1:0] line_width;
    logic             rle_enable;
    logic             in_write;
    logic [7:0]       in_pixel;
    logic             in_strobe;
    logic             out_write;
    logic [7:0]       out_pixel;
    logic             out_strobe;
    logic             line_done;

    rl7_line_decoder #(.unit_index(0), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .line_width (line_width),
        .rle_enable (rle_enable),
        .in_write   (in_write),
        .in_pixel   (in_pixel),
        .in_strobe  (in_strobe),
        .out_write  (out_write),
        .out_pixel  (out_pixel),
        .out_strobe (out_strobe),
        .line_done  (line_done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] stream_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         bi;
    bit         hold_v = 1'b0;
    logic [7:0] hold_pix;
    int         model_consumed;
    bit         model_done;
    int         last_cycles;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decode a whole line from the byte list by the RL7 rules.
    function automatic void model_line(input int width, input bit rle);
        int         pos = 0;
        int         i = 0;
        int         cnt;
        logic [7:0] b;
        logic [7:0] n;
        exp_q.delete();
        while ((pos < width) && (i < stream_q.size())) begin
            b = stream_q[i];
            i++;
            if (!rle || (b < 8'h80)) begin
                exp_q.push_back(b);
                pos++;
            end else if (i < stream_q.size()) begin
                n = stream_q[i];
                i++;
                cnt = width - pos;
                if ((n != 8'd0) && (int'(n) < cnt)) cnt = int'(n);
                repeat (cnt) exp_q.push_back(b - 8'h80);
                pos += cnt;
            end
        end
        model_consumed = i;
        model_done     = (pos == width);
    endfunction

    task automatic build_stream(input int width, input bit rle);
        int r;
        stream_q.delete();
        while (stream_q.size() < 2 * width + 4) begin
            r = int'($urandom_range(9));
            if (!rle) begin
                stream_q.push_back(8'($urandom));
            end else if (r < 5) begin
                stream_q.push_back(8'($urandom_range(127)));
            end else begin
                stream_q.push_back(8'h80 | 8'($urandom_range(127)));
                r = int'($urandom_range(9));
                if (r == 0)     stream_q.push_back(8'h00);
                else if (r < 8) stream_q.push_back(8'($urandom_range(6, 1)));
                else            stream_q.push_back(8'($urandom_range(255, 1)));
            end
        end
    endtask

    task automatic drive(input int gap_pct, input int strobe_pct);
        if ((bi < stream_q.size()) && (int'($urandom_range(99)) >= gap_pct)) begin
            in_write = 1'b1;
            in_pixel = stream_q[bi];
        end else begin
            in_write = 1'b0;
            in_pixel = 8'($urandom);
        end
        out_strobe = (int'($urandom_range(99)) < strobe_pct);
    endtask

    // One clock: observe handshakes at the falling edge, resume after rising edge.
    task automatic step();
        @(negedge clk);
        if (in_write && in_strobe) bi++;
        if (hold_v) begin
            check_eq("hold_write", int'(out_write), 1);
            check_eq("hold_pixel", int'(out_pixel), int'(hold_pix));
        end
        hold_v   = out_write && !out_strobe && !line_start;
        hold_pix = out_pixel;
        if (out_write && out_strobe) got_q.push_back(out_pixel);
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input string name, input int width, input bit rle);
        line_start = 1'b1;
        line_width = CNT_W'(width);
        rle_enable = rle;
        if (stream_q.size() > 0) begin
            in_write = 1'b1;
            in_pixel = stream_q[0];
        end else begin
            in_write = 1'b0;
            in_pixel = 8'h00;
        end
        out_strobe = 1'b1;
        @(negedge clk);
        check_eq({name, "_ls_take"}, int'(in_strobe), 0);
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        check_eq({name, "_ls_write"}, int'(out_write), 0);
        check_eq({name, "_ls_done"}, int'(line_done), 0);
    endtask

    task automatic run_line(input string name, input int width, input bit rle,
                            input int gap_pct, input int strobe_pct);
        int budget;
        model_line(width, rle);
        bi = 0;
        got_q.delete();
        start_line(name, width, rle);
        budget      = 8 * width + 100;
        last_cycles = 0;
        while ((got_q.size() < exp_q.size()) && (budget > 0)) begin
            drive(gap_pct, strobe_pct);
            step();
            budget--;
            last_cycles++;
        end
        repeat (6) begin
            drive(gap_pct, 100);
            step();
        end
        check_eq({name, "_npix"}, got_q.size(), exp_q.size());
        check_eq({name, "_consumed"}, bi, model_consumed);
        check_eq({name, "_line_done"}, int'(line_done), model_done ? 1 : 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq({name, "_pix"}, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  rle;
        reset_n    = 1'b0;
        line_start = 1'b0;
        line_width = {CNT_W{1'b0}};
        rle_enable = 1'b0;
        in_write   = 1'b1;
        in_pixel   = 8'h81;
        out_strobe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_write", int'(out_write), 0);
        check_eq("rst_out_pixel", int'(out_pixel), 0);
        check_eq("rst_in_strobe", int'(in_strobe), 0);
        check_eq("rst_line_done", int'(line_done), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_in_strobe", int'(in_strobe), 0);
        @(posedge clk);
        #1;

        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_line("singles", 4, 1'b1, 0, 100);
        check_eq("singles_cycles", last_cycles, 5);

        stream_q = '{8'h85, 8'h03, 8'h0A};
        run_line("run_part", 8, 1'b1, 0, 100);

        stream_q = '{8'h11, 8'h22, 8'h81, 8'h00, 8'h33};
        run_line("run_end", 8, 1'b1, 0, 100);

        stream_q = '{8'h07, 8'h90, 8'h09, 8'h55};
        run_line("trunc", 5, 1'b1, 0, 100);

        stream_q = '{8'h85, 8'h04};
        run_line("backpr", 10, 1'b1, 0, 40);

        stream_q = '{8'h83, 8'h02, 8'h81, 8'h01, 8'hC4, 8'h05};
        run_line("byp_raw", 6, 1'b0, 20, 70);

        for (int k = 0; k < 30; k++) begin
            w   = int'($urandom_range(40, 1));
            rle = ($urandom_range(3) != 0);
            build_stream(w, rle);
            run_line(rle ? "rand_rl7" : "rand_byp", w, rle,
                     int'($urandom_range(30)), int'($urandom_range(100, 50)));
        end

        // Asynchronous reset in the middle of a run
        stream_q = '{8'h85, 8'h20};
        bi = 0;
        got_q.delete();
        start_line("rst_mid", 40, 1'b1);
        repeat (4) begin
            drive(0, 100);
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_write", int'(out_write), 0);
        check_eq("rst_mid_done", int'(line_done), 1);
        check_eq("rst_mid_take", int'(in_strobe), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold_v  = 1'b0;

        // line_start in the middle of a long run, then a one-pixel bypass line
        stream_q = '{8'h83, 8'hFF};
        bi = 0;
        got_q.delete();
        start_line("mid", 300, 1'b1);
        w = 50;
        while ((got_q.size() < 3) && (w > 0)) begin
            drive(0, 100);
            step();
            w--;
        end
        check_eq("mid_npix", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("mid_pix", (i < got_q.size()) ? int'(got_q[i]) : -1, 8'h03);
        end
        stream_q = '{8'hAB};
        run_line("mid_byp", 1, 1'b0, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
